frame_rect_writer: RTL and testbench

FRAME_RECT_WRITER -- requirements
Module: frame_rect_writer

---
 rtl/frame_rect_writer_pkg.sv | 37 +++
 rtl/frame_rect_writer_row_base_calc.sv | 37 +++
 rtl/frame_rect_writer.sv | 135 +++++++++++++
 tb/tb_frame_rect_writer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_rect_writer_pkg.sv
// Shared definitions for the frame-buffer writer and the image-RAM reader:
// screen geometry, writer state encoding, 3-bit RGB colour constants.
package frame_rect_writer_pkg;

  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  localparam int ADDR_W   = 19;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } rect_state_t;

  // Colour bits are {R, G, B}
  localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
  localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
  localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
  localparam logic [COLOUR_W-1:0] RED     = 3'b100;
  localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
  localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
  localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

  // Visible extent of a span starting at origin; evaluated in int so that
  // origin + len never wraps at the port width.
  function automatic int clip_extent(input int origin, input int len, input int limit);
    if (origin >= limit) return 0;
    return (len < (limit - origin)) ? len : (limit - origin);
  endfunction

endpackage

// File: rtl/frame_rect_writer_row_base_calc.sv
// Row base address y*SCREEN_W built as a sum of shifted copies of y,
// one term per set bit of SCREEN_W, so no multiplier is inferred.
module row_base_calc
  import frame_rect_writer_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT
) (
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] base
);

  localparam logic [ADDR_W-1:0] MULT = ADDR_W'(SCREEN_W);

  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] partial [0:ADDR_W-1];

  assign y_ext = {{(ADDR_W-Y_W){1'b0}}, y};

  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_term
      logic [ADDR_W-1:0] term;
      if (MULT[gi]) begin : g_on
        assign term = y_ext << gi;
      end else begin : g_off
        assign term = '0;
      end
      if (gi == 0) begin : g_first
        assign partial[gi] = term;
      end else begin : g_acc
        assign partial[gi] = partial[gi-1] + term;
      end
    end
  endgenerate

  assign base = partial[ADDR_W-1];

endmodule

// File: rtl/frame_rect_writer.sv
// Fills a clipped rectangle of the frame buffer with one colour, one pixel
// per cycle in raster order, and pulses done when the fill is complete.
module frame_rect_writer
  import frame_rect_writer_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] colour,
  output logic [ADDR_W-1:0]   address,
  output logic [COLOUR_W-1:0] dataout,
  output logic                wren,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_W);

  rect_state_t state_reg, state_next;

  logic [X_W-1:0]      x0_reg;
  logic [Y_W-1:0]      y0_reg;
  logic [X_W-1:0]      w_reg;
  logic [Y_W-1:0]      h_reg;
  logic [COLOUR_W-1:0] colour_reg;

  logic [X_W-1:0]      w_eff_reg;
  logic [Y_W-1:0]      h_eff_reg;
  logic [X_W-1:0]      x_cnt_reg;
  logic [Y_W-1:0]      y_cnt_reg;
  logic [X_W-1:0]      col_reg;
  logic [ADDR_W-1:0]   row_base_reg;

  logic [X_W-1:0]      w_eff_next;
  logic [Y_W-1:0]      h_eff_next;
  logic [ADDR_W-1:0]   row_base_start;
  logic                clip_empty;
  logic                last_col;
  logic                last_row;

  row_base_calc #(.SCREEN_W(SCREEN_W)) u_row_base (
    .y    (y0_reg),
    .base (row_base_start)
  );

  assign w_eff_next = X_W'(clip_extent(int'(x0_reg), int'(w_reg), SCREEN_W));
  assign h_eff_next = Y_W'(clip_extent(int'(y0_reg), int'(h_reg), SCREEN_H));
  assign clip_empty = (w_eff_next == '0) || (h_eff_next == '0);

  assign last_col = (x_cnt_reg == (w_eff_reg - X_W'(1)));
  assign last_row = (y_cnt_reg == (h_eff_reg - Y_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_CLIP;
      S_CLIP: state_next = clip_empty ? S_DONE : S_DRAW;
      S_DRAW: if (last_col && last_row) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request fields are captured only in IDLE, so later changes on the
  // inputs cannot disturb a fill in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_reg       <= '0;
      y0_reg       <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      colour_reg   <= BLACK;
      w_eff_reg    <= '0;
      h_eff_reg    <= '0;
      x_cnt_reg    <= '0;
      y_cnt_reg    <= '0;
      col_reg      <= '0;
      row_base_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            x0_reg     <= x0;
            y0_reg     <= y0;
            w_reg      <= w;
            h_reg      <= h;
            colour_reg <= colour;
          end
        end
        S_CLIP: begin
          w_eff_reg    <= w_eff_next;
          h_eff_reg    <= h_eff_next;
          x_cnt_reg    <= '0;
          y_cnt_reg    <= '0;
          col_reg      <= x0_reg;
          row_base_reg <= row_base_start;
        end
        S_DRAW: begin
          if (last_col) begin
            x_cnt_reg    <= '0;
            col_reg      <= x0_reg;
            y_cnt_reg    <= y_cnt_reg + Y_W'(1);
            row_base_reg <= row_base_reg + ROW_STEP;
          end else begin
            x_cnt_reg <= x_cnt_reg + X_W'(1);
            col_reg   <= col_reg + X_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wren    = (state_reg == S_DRAW);
  assign address = wren ? (row_base_reg + {{(ADDR_W-X_W){1'b0}}, col_reg}) : '0;
  assign dataout = wren ? colour_reg : BLACK;
  assign busy    = (state_reg != S_IDLE);
  assign done    = (state_reg == S_DONE);

endmodule

// File: tb/tb_frame_rect_writer.sv
// Directed bench for frame_rect_writer at the default 640x480 geometry.
module tb_frame_rect_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  x0;
  logic [8:0]  y0;
  logic [9:0]  w;
  logic [8:0]  h;
  logic [2:0]  colour;
  logic [18:0] address;
  logic [2:0]  dataout;
  logic        wren;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  int q_addr[$];
  int q_data[$];
  int done_at;
  int busy_cnt;
  int done_cnt;

  int obs_busy [1:8];
  int obs_done [1:8];
  int obs_wren [1:8];
  int obs_addr [1:8];

  frame_rect_writer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .x0      (x0),
    .y0      (y0),
    .w       (w),
    .h       (h),
    .colour  (colour),
    .address (address),
    .dataout (dataout),
    .wren    (wren),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drives one start pulse and logs every write; k counts negedges after the
  // accepting edge. Optionally pokes start mid-fill or aborts with reset.
  task automatic run_fill(input string tag, input int x, input int y, input int ww, input int hh,
                          input int c, input int poke_at, input int abort_at, input int budget);
    bit finished = 0;
    q_addr.delete();
    q_data.delete();
    done_at  = -1;
    busy_cnt = 0;
    done_cnt = 0;
    x0 = 10'(x); y0 = 9'(y); w = 10'(ww); h = 9'(hh); colour = 3'(c);
    start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (wren) begin
        q_addr.push_back(int'(address));
        q_data.push_back(int'(dataout));
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (abort_at > 0 && k == abort_at + 1) begin
        check({tag, "_abort_wren"}, 32'(wren), 32'd0);
        check({tag, "_abort_busy"}, 32'(busy), 32'd0);
        check({tag, "_abort_done"}, 32'(done), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        return;
      end
      start = (k == poke_at);
      if (k == poke_at) begin
        colour = 3'(~c); x0 = 10'd0; y0 = 9'd0; w = 10'd1; h = 9'd1;
      end
      if (abort_at > 0 && k == abort_at) reset = 1'b1;
      if (done) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    if (!finished) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
    end
  endtask

  // Compares the logged fill against an independent clip/raster model.
  task automatic verify(input string tag, input int x, input int y, input int ww, input int hh, input int c);
    int we, he, n;
    we = (x >= 640) ? 0 : ((ww < 640 - x) ? ww : 640 - x);
    he = (y >= 480) ? 0 : ((hh < 480 - y) ? hh : 480 - y);
    n  = we * he;
    check({tag, "_count"}, 32'(q_addr.size()), 32'(n));
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'((y + i / we) * 640 + x + i % we));
      check($sformatf("%s_data%0d", tag, i), 32'(q_data[i]), 32'(c));
    end
    check({tag, "_done_at"}, 32'(done_at), 32'(2 + n));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(2 + n));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; colour = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);

    // reset wins over a simultaneous start
    x0 = 10'd1; y0 = 9'd1; w = 10'd2; h = 9'd2; colour = 3'd7; start = 1'b1;
    @(negedge clk);
    check("rst_prio_busy", 32'(busy), 32'd0);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("rst_prio_idle", 32'(busy), 32'd0);

    run_fill("basic", 10, 20, 3, 2, 3'b100, 0, 0, 50);
    verify("basic", 10, 20, 3, 2, 3'b100);
    check("basic_hand0", 32'(q_addr.size() > 0 ? q_addr[0] : -1), 32'd12810);
    check("basic_hand3", 32'(q_addr.size() > 3 ? q_addr[3] : -1), 32'd13450);
    check("basic_hand5", 32'(q_addr.size() > 5 ? q_addr[5] : -1), 32'd13452);
    check("basic_hand_done", 32'(done_at), 32'd8);

    run_fill("corner", 638, 479, 10, 10, 3'b011, 0, 0, 50);
    verify("corner", 638, 479, 10, 10, 3'b011);
    check("corner_hand0", 32'(q_addr.size() > 0 ? q_addr[0] : -1), 32'd307198);
    check("corner_hand1", 32'(q_addr.size() > 1 ? q_addr[1] : -1), 32'd307199);

    run_fill("edge_fit", 637, 0, 3, 1, 3'b001, 0, 0, 50);
    verify("edge_fit", 637, 0, 3, 1, 3'b001);

    run_fill("x_off", 700, 10, 5, 5, 3'b010, 0, 0, 50);
    verify("x_off", 700, 10, 5, 5, 3'b010);
    check("x_off_done_hand", 32'(done_at), 32'd2);

    run_fill("w_zero", 10, 10, 0, 5, 3'b010, 0, 0, 50);
    verify("w_zero", 10, 10, 0, 5, 3'b010);

    run_fill("y_off", 10, 480, 4, 4, 3'b110, 0, 0, 50);
    verify("y_off", 10, 480, 4, 4, 3'b110);

    run_fill("poke", 5, 5, 4, 4, 3'b010, 5, 0, 60);
    verify("poke", 5, 5, 4, 4, 3'b010);

    run_fill("abort", 0, 1, 4, 4, 3'b111, 0, 4, 60);
    check("abort_writes", 32'(q_addr.size()), 32'd3);
    check("abort_last_addr", 32'(q_addr.size() > 2 ? q_addr[2] : -1), 32'd642);

    run_fill("after_abort", 0, 1, 4, 4, 3'b111, 0, 0, 60);
    verify("after_abort", 0, 1, 4, 4, 3'b111);

    run_fill("bottom", 0, 476, 640, 100, 3'b101, 0, 0, 3000);
    verify("bottom", 0, 476, 640, 100, 3'b101);
    check("bottom_first", 32'(q_addr.size() > 0 ? q_addr[0] : -1), 32'd304640);
    check("bottom_last", 32'(q_addr.size() > 0 ? q_addr[q_addr.size()-1] : -1), 32'd307199);

    // start held high relaunches in the IDLE cycle after DONE
    x0 = 10'd100; y0 = 9'd100; w = 10'd1; h = 9'd1; colour = 3'd6; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      obs_busy[k] = int'(busy);
      obs_done[k] = int'(done);
      obs_wren[k] = int'(wren);
      obs_addr[k] = int'(address);
      start = (k < 6);
    end
    check("hold_first_write", 32'(obs_wren[2]), 32'd1);
    check("hold_done1", 32'(obs_done[3]), 32'd1);
    check("hold_idle_gap", 32'(obs_busy[4]), 32'd0);
    check("hold_relaunch_busy", 32'(obs_busy[5]), 32'd1);
    check("hold_relaunch_wren", 32'(obs_wren[6]), 32'd1);
    check("hold_relaunch_addr", 32'(obs_addr[6]), 32'd64100);
    check("hold_done2", 32'(obs_done[7]), 32'd1);
    check("hold_final_idle", 32'(obs_busy[8]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
